controle_ula_multiciclo: RTL and testbench
==========================================

Name: controle_ula_multiciclo

Overview:
- Parametrised successor to the single-cycle MIPS ALU control decoder.
- Decodes ALUOp/funct into a wider ALU control code and adds logical ops, unsigned compare and an illegal-instruction flag.
- Owns an iterative sequencer for mult/div that holds HI/LO and stalls the pipeline while busy.
- Sits between the main control unit and the ULA/register file in the mips-cpu datapath.

Parameters:
- DATA_W, 32: operand, HI and LO width (>=4).
- ALUCON_W, 4: width of the ALUCon output (>=4).
- SIGNED_MD, 1: 1 = signed mult/div with sign fix-up; 0 = unsigned.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- ALUOp  in  6  instruction opcode field.
- funct  in  6  R-type funct field.
- in_valid  in  1  instruction in decode this cycle.
- op_a  in  DATA_W  rs operand.
- op_b  in  DATA_W  rt operand.
- ALUCon  out  ALUCON_W  combinational ALU control code.
- illegal  out  1  combinational; opcode/funct not in the table.
- busy  out  1  sequencer in an iteration state.
- stall  out  1  hold the front of the pipeline this cycle.
- done  out  1  one-cycle pulse; hi/lo just updated.
- hi  out  DATA_W  HI register (remainder / upper product).
- lo  out  DATA_W  LO register (quotient / lower product).
- div0  out  1  last div had a zero divisor; sticky until the next accepted mult/div.

Behaviour:
- Reset values: hi=0, lo=0, done=0, busy=0, div0=0, state=IDLE. ALUCon and illegal are combinational.
- Decode, R-type (ALUOp=000000), by funct:
  - 100000 add -> 0000
  - 100010 sub -> 0001
  - 011000 mult -> 0010
  - 011010 div -> 0011
  - 101010 slt -> 0100
  - 100100 and -> 0101
  - 100101 or -> 0110
  - 100111 nor -> 0111
  - 101011 sltu -> 1000
  - 001000 jr -> 0000
  - 010000 mfhi -> 1001
  - 010010 mflo -> 1010
- Decode, I/J-type, by ALUOp:
  - addi 001000 -> 0000
  - slti 001010 -> 0100
  - andi 001100 -> 0101
  - ori 001101 -> 0110
  - beq 000100 -> 0001 (sub, for the zero test)
  - j 000010, jal 000011, lw 100011, sw 101011 -> 0000
- Any other opcode or funct: ALUCon=0000, illegal=1. ALUCon is zero-extended to ALUCON_W.
- Sequencer states: IDLE, MULT, DIV, DONE.
- IDLE -> MULT/DIV when in_valid=1 and the decode is mult/div. Operands are latched that cycle (the accept cycle) and the iteration counter is loaded with DATA_W.
- MULT: one shift-add step per cycle, on operand magnitudes when SIGNED_MD=1.
- DIV: one restoring shift-subtract step per cycle.
- The counter decrements each iteration cycle. At count 1 the FSM goes to DONE.
- DONE: sign fix-up applied, hi/lo written, done=1 for exactly this cycle, then IDLE.
- Latency: done is high DATA_W+1 cycles after the accept edge (DATA_W=32 -> cycle 33). hi/lo hold their old values until DONE.
- busy=1 in MULT and DIV only.
- stall = busy, OR in_valid & (mfhi|mflo|mult|div) & state!=IDLE, OR in_valid & (mult|div) & state==IDLE (the accept cycle itself).
- Non-mult/div instructions never stall unless the sequencer is busy.
- A mult/div or mfhi/mflo arriving in DONE stalls one cycle. A mult/div is accepted only in IDLE.
- Signed division truncates toward zero. The remainder takes the dividend's sign.
- Divide by zero: no iteration. Next cycle goes to DONE with lo = all ones, hi = op_a, div0=1.
- Most-negative / -1: lo = most-negative, hi = 0, no flag.
- reset during any state aborts the operation: all outputs return to reset values next cycle.
- in_valid=0 with a mult/div decode does nothing.

Decomposition:
- Shared package ula_pkg holds:
  - ALUCon encodings as localparams
  - opcode and funct constants
  - the state enum (IDLE/MULT/DIV/DONE)
- Sub-module ula_muldiv_iter holds the iterative datapath: accumulator, shifter, counter, sign fix-up.
- The top level keeps the decode, FSM, stall and handshake logic.

Test Plan:
- Decode sweep: every table opcode/funct -> listed ALUCon, illegal=0. ALUOp=111111 -> ALUCon=0000, illegal=1. R-type funct=111111 -> illegal=1.
- Signed mult: op_a=7, op_b=FFFFFFFD (-3) -> done at cycle 33, hi=FFFFFFFF, lo=FFFFFFEB; busy high cycles 1-32; stall high on the accept cycle.
- Signed div: op_a=100, op_b=7 -> lo=0000000E, hi=00000002. Then op_a=FFFFFFF9, op_b=2 -> lo=FFFFFFFD, hi=FFFFFFFF.
- Divide by zero: op_a=5, op_b=0 -> done 2 cycles after accept, lo=FFFFFFFF, hi=00000005, div0=1. The next mult clears div0.
- Hazard: mflo issued 3 cycles after a mult -> stall held until the cycle after done; add issued with no mult/div pending -> stall=0.
- Reset at cycle 10 of a div -> next cycle busy=0, done=0, hi=lo=0; no done pulse follows.

Source files
------------

// File: rtl/ula_pkg.sv
// Shared encodings for the multicycle ALU control: ALU control codes,
// MIPS opcode/funct values and the mult/div sequencer states.
package ula_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_MULT = 4'b0010;
  localparam logic [3:0] ALU_DIV  = 4'b0011;
  localparam logic [3:0] ALU_SLT  = 4'b0100;
  localparam logic [3:0] ALU_AND  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_NOR  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_MFHI = 4'b1001;
  localparam logic [3:0] ALU_MFLO = 4'b1010;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLTU  = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } seq_state_e;

endpackage

// File: rtl/ula_muldiv_iter.sv
// Iterative mult/div datapath: shift-add multiply, restoring divide,
// iteration counter and final sign fix-up of the result.
module ula_muldiv_iter #(
  parameter int unsigned DATA_W    = 32,
  parameter bit          SIGNED_MD = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              div_i,
  input  logic              step_i,
  input  logic [DATA_W-1:0] op_a_i,
  input  logic [DATA_W-1:0] op_b_i,
  output logic              last_o,
  output logic              divz_o,
  output logic [DATA_W-1:0] res_hi_o,
  output logic [DATA_W-1:0] res_lo_o
);

  localparam int unsigned CW = $clog2(DATA_W + 1);

  logic [DATA_W:0]     p_q, p_d;
  logic [DATA_W-1:0]   q_q, q_d;
  logic [DATA_W-1:0]   m_q, a_raw_q;
  logic                div_q, neg_q_q, neg_r_q;
  logic [CW-1:0]       cnt_q;

  logic                a_neg, b_neg;
  logic [DATA_W-1:0]   mag_a, mag_b;
  logic [DATA_W:0]     r_sh, addend, sum;
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]   quot, rem;

  always_comb begin
    a_neg = SIGNED_MD && op_a_i[DATA_W-1];
    b_neg = SIGNED_MD && op_b_i[DATA_W-1];
    mag_a = a_neg ? -op_a_i : op_a_i;
    mag_b = b_neg ? -op_b_i : op_b_i;
  end

  // p holds the partial product high half (mult) or partial remainder (div);
  // q holds the multiplier/quotient bits shifting through.
  always_comb begin
    r_sh   = '0;
    addend = '0;
    sum    = '0;
    p_d    = p_q;
    q_d    = q_q;
    if (div_q) begin
      r_sh = {p_q[DATA_W-1:0], q_q[DATA_W-1]};
      if (r_sh >= {1'b0, m_q}) begin
        p_d = r_sh - {1'b0, m_q};
        q_d = {q_q[DATA_W-2:0], 1'b1};
      end else begin
        p_d = r_sh;
        q_d = {q_q[DATA_W-2:0], 1'b0};
      end
    end else begin
      addend = q_q[0] ? {1'b0, m_q} : '0;
      sum    = p_q + addend;
      p_d    = {1'b0, sum[DATA_W:1]};
      q_d    = {sum[0], q_q[DATA_W-1:1]};
    end
  end

  // Results reflect the step being taken this cycle, so the caller can
  // capture them on the same edge as the final iteration.
  always_comb begin
    prod = {p_d[DATA_W-1:0], q_d};
    if (neg_q_q) prod = -prod;
    quot = neg_q_q ? -q_d : q_d;
    rem  = neg_r_q ? -p_d[DATA_W-1:0] : p_d[DATA_W-1:0];
    if (divz_o) begin
      res_hi_o = a_raw_q;
      res_lo_o = '1;
    end else if (div_q) begin
      res_hi_o = rem;
      res_lo_o = quot;
    end else begin
      res_hi_o = prod[2*DATA_W-1:DATA_W];
      res_lo_o = prod[DATA_W-1:0];
    end
  end

  assign last_o = (cnt_q == CW'(1));
  assign divz_o = div_q && (m_q == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      p_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      a_raw_q <= '0;
      div_q   <= 1'b0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      cnt_q   <= '0;
    end else if (load_i) begin
      p_q     <= '0;
      q_q     <= div_i ? mag_a : mag_b;
      m_q     <= div_i ? mag_b : mag_a;
      a_raw_q <= op_a_i;
      div_q   <= div_i;
      neg_q_q <= a_neg ^ b_neg;
      neg_r_q <= a_neg;
      cnt_q   <= CW'(DATA_W);
    end else if (step_i) begin
      p_q   <= p_d;
      q_q   <= q_d;
      cnt_q <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/controle_ula_multiciclo.sv
// ALU control decoder with an iterative mult/div sequencer that owns HI/LO
// and stalls the pipeline front while a mult/div is outstanding.
module controle_ula_multiciclo
  import ula_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ALUCON_W  = 4,
  parameter bit          SIGNED_MD = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [5:0]          ALUOp,
  input  logic [5:0]          funct,
  input  logic                in_valid,
  input  logic [DATA_W-1:0]   op_a,
  input  logic [DATA_W-1:0]   op_b,
  output logic [ALUCON_W-1:0] ALUCon,
  output logic                illegal,
  output logic                busy,
  output logic                stall,
  output logic                done,
  output logic [DATA_W-1:0]   hi,
  output logic [DATA_W-1:0]   lo,
  output logic                div0
);

  seq_state_e        state_q, state_d;
  logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;
  logic              div0_q, div0_d;

  logic [3:0]        code;
  logic              is_mult, is_div, is_mfx, is_md;
  logic              load, step, it_last, it_divz;
  logic [DATA_W-1:0] res_hi, res_lo;

  always_comb begin
    code    = ALU_ADD;
    illegal = 1'b0;
    if (ALUOp == OP_RTYPE) begin
      case (funct)
        FN_ADD:  code = ALU_ADD;
        FN_SUB:  code = ALU_SUB;
        FN_MULT: code = ALU_MULT;
        FN_DIV:  code = ALU_DIV;
        FN_SLT:  code = ALU_SLT;
        FN_AND:  code = ALU_AND;
        FN_OR:   code = ALU_OR;
        FN_NOR:  code = ALU_NOR;
        FN_SLTU: code = ALU_SLTU;
        FN_JR:   code = ALU_ADD;
        FN_MFHI: code = ALU_MFHI;
        FN_MFLO: code = ALU_MFLO;
        default: illegal = 1'b1;
      endcase
    end else begin
      case (ALUOp)
        OP_ADDI: code = ALU_ADD;
        OP_SLTI: code = ALU_SLT;
        OP_ANDI: code = ALU_AND;
        OP_ORI:  code = ALU_OR;
        OP_BEQ:  code = ALU_SUB;
        OP_J, OP_JAL, OP_LW, OP_SW: code = ALU_ADD;
        default: illegal = 1'b1;
      endcase
    end
  end

  assign ALUCon  = ALUCON_W'(code);
  assign is_mult = (ALUOp == OP_RTYPE) && (funct == FN_MULT);
  assign is_div  = (ALUOp == OP_RTYPE) && (funct == FN_DIV);
  assign is_mfx  = (ALUOp == OP_RTYPE) && ((funct == FN_MFHI) || (funct == FN_MFLO));
  assign is_md   = is_mult || is_div;

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    div0_d  = div0_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && is_md) begin
          load    = 1'b1;
          div0_d  = 1'b0;
          state_d = is_div ? DIV : MULT;
        end
      end
      MULT: begin
        if (it_last) begin
          state_d = DONE;
          hi_d    = res_hi;
          lo_d    = res_lo;
        end
      end
      DIV: begin
        // A zero divisor short-circuits the iteration on the first DIV cycle.
        if (it_divz || it_last) begin
          state_d = DONE;
          hi_d    = res_hi;
          lo_d    = res_lo;
          div0_d  = it_divz;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy  = (state_q == MULT) || (state_q == DIV);
  assign step  = busy;
  assign done  = (state_q == DONE);
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign div0  = div0_q;
  assign stall = busy
              || (in_valid && (is_md || is_mfx) && (state_q != IDLE))
              || (in_valid && is_md && (state_q == IDLE));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      div0_q  <= div0_d;
    end
  end

  ula_muldiv_iter #(
    .DATA_W    (DATA_W),
    .SIGNED_MD (SIGNED_MD)
  ) u_iter (
    .clk      (clk),
    .reset    (reset),
    .load_i   (load),
    .div_i    (is_div),
    .step_i   (step),
    .op_a_i   (op_a),
    .op_b_i   (op_b),
    .last_o   (it_last),
    .divz_o   (it_divz),
    .res_hi_o (res_hi),
    .res_lo_o (res_lo)
  );

endmodule

// File: tb/tb_controle_ula_multiciclo.sv
// Bench for controle_ula_multiciclo: arithmetic reference model checked every
// cycle, plus directed vectors with literal expectations.
module tb_controle_ula_multiciclo;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  ALUOp, funct;
  logic        in_valid;
  logic [31:0] op_a, op_b;
  logic [3:0]  ALUCon;
  logic        illegal, busy, stall, done, div0;
  logic [31:0] hi, lo;

  always #5 clk = ~clk;

  controle_ula_multiciclo #(
    .DATA_W    (32),
    .ALUCON_W  (4),
    .SIGNED_MD (1'b1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ALUOp    (ALUOp),
    .funct    (funct),
    .in_valid (in_valid),
    .op_a     (op_a),
    .op_b     (op_b),
    .ALUCon   (ALUCon),
    .illegal  (illegal),
    .busy     (busy),
    .stall    (stall),
    .done     (done),
    .hi       (hi),
    .lo       (lo),
    .div0     (div0)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // {illegal, code} from the instruction table
  function automatic logic [4:0] ref_dec(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h00) begin
      case (fn)
        6'h20: return 5'h00;
        6'h22: return 5'h01;
        6'h18: return 5'h02;
        6'h1a: return 5'h03;
        6'h2a: return 5'h04;
        6'h24: return 5'h05;
        6'h25: return 5'h06;
        6'h27: return 5'h07;
        6'h2b: return 5'h08;
        6'h08: return 5'h00;
        6'h10: return 5'h09;
        6'h12: return 5'h0a;
        default: return 5'h10;
      endcase
    end
    case (op)
      6'h08, 6'h02, 6'h03, 6'h23, 6'h2b: return 5'h00;
      6'h0a: return 5'h04;
      6'h0c: return 5'h05;
      6'h0d: return 5'h06;
      6'h04: return 5'h01;
      default: return 5'h10;
    endcase
  endfunction

  function automatic bit f_md(input logic [5:0] op, input logic [5:0] fn);
    return (op == 6'h00) && (fn == 6'h18 || fn == 6'h1a);
  endfunction

  function automatic bit f_mf(input logic [5:0] op, input logic [5:0] fn);
    return (op == 6'h00) && (fn == 6'h10 || fn == 6'h12);
  endfunction

  // Model: t counts cycles since the accept edge; busy for t in 1..lat,
  // done at t = lat+1, results visible from that cycle on.
  bit          m_act = 1'b0;
  int          m_t = 0, m_lat = 0;
  logic [31:0] m_hi = '0, m_lo = '0, r_hi, r_lo;
  bit          m_div0 = 1'b0, r_dz;
  longint      sa, sb, prod, qq, rr;

  always @(posedge clk) begin
    if (reset) begin
      m_act = 1'b0; m_t = 0; m_hi = '0; m_lo = '0; m_div0 = 1'b0;
    end else if (m_act) begin
      if (m_t == m_lat + 1) m_act = 1'b0;
      else begin
        m_t++;
        if (m_t == m_lat + 1) begin
          m_hi = r_hi; m_lo = r_lo;
          if (r_dz) m_div0 = 1'b1;
        end
      end
    end else if (in_valid && f_md(ALUOp, funct)) begin
      m_act = 1'b1; m_t = 1; m_div0 = 1'b0; r_dz = 1'b0; m_lat = 32;
      sa = longint'($signed(op_a));
      sb = longint'($signed(op_b));
      if (funct == 6'h18) begin
        prod = sa * sb;
        r_hi = prod[63:32]; r_lo = prod[31:0];
      end else if (op_b == 32'd0) begin
        r_hi = op_a; r_lo = 32'hFFFF_FFFF; r_dz = 1'b1; m_lat = 1;
      end else begin
        qq = sa / sb; rr = sa % sb;
        r_hi = rr[31:0]; r_lo = qq[31:0];
      end
    end
  end

  logic [4:0] e_dec;
  bit         e_busy, e_done, e_stall;

  always @(negedge clk) begin
    if (chk_en) begin
      e_dec   = ref_dec(ALUOp, funct);
      e_busy  = m_act && (m_t <= m_lat);
      e_done  = m_act && (m_t == m_lat + 1);
      e_stall = e_busy || (in_valid && (f_md(ALUOp, funct) || f_mf(ALUOp, funct)) && m_act)
                       || (in_valid && f_md(ALUOp, funct) && !m_act);
      chk("m_alucon",  64'(ALUCon),  64'(e_dec[3:0]));
      chk("m_illegal", 64'(illegal), 64'(e_dec[4]));
      chk("m_busy",    64'(busy),    64'(e_busy));
      chk("m_done",    64'(done),    64'(e_done));
      chk("m_stall",   64'(stall),   64'(e_stall));
      chk("m_hi",      64'(hi),      64'(m_hi));
      chk("m_lo",      64'(lo),      64'(m_lo));
      chk("m_div0",    64'(div0),    64'(m_div0));
    end
  end

  localparam int NSW = 24;
  logic [5:0] sw_op   [NSW] = '{6'h00,6'h00,6'h00,6'h00,6'h00,6'h00,6'h00,6'h00,6'h00,6'h00,6'h00,6'h00,
                                6'h08,6'h0a,6'h0c,6'h0d,6'h04,6'h02,6'h03,6'h23,6'h2b,
                                6'h3f,6'h00,6'h00};
  logic [5:0] sw_fn   [NSW] = '{6'h20,6'h22,6'h18,6'h1a,6'h2a,6'h24,6'h25,6'h27,6'h2b,6'h08,6'h10,6'h12,
                                6'h15,6'h15,6'h15,6'h15,6'h15,6'h15,6'h15,6'h15,6'h15,
                                6'h00,6'h3f,6'h00};
  logic [3:0] sw_code [NSW] = '{4'h0,4'h1,4'h2,4'h3,4'h4,4'h5,4'h6,4'h7,4'h8,4'h0,4'h9,4'hA,
                                4'h0,4'h4,4'h5,4'h6,4'h1,4'h0,4'h0,4'h0,4'h0,
                                4'h0,4'h0,4'h0};
  logic       sw_ill  [NSW] = '{0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0, 1,1,1};

  task automatic run_md(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                        input int exp_cyc, input logic [31:0] ehi, input logic [31:0] elo,
                        input bit ediv0);
    int cyc;
    ALUOp = 6'h00; funct = fn; op_a = a; op_b = b; in_valid = 1'b1;
    @(negedge clk);
    chk("accept_stall", 64'(stall), 64'(1));
    @(posedge clk); #1;
    in_valid = 1'b0; funct = 6'h20;
    cyc = 0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (done) begin
        cyc = n;
        break;
      end
      @(posedge clk); #1;
    end
    chk("done_cycle", 64'(cyc), 64'(exp_cyc));
    chk("res_hi", 64'(hi), 64'(ehi));
    chk("res_lo", 64'(lo), 64'(elo));
    chk("res_div0", 64'(div0), 64'(ediv0));
    if (cyc != 0) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int rel, pulses;
    reset = 1'b1; in_valid = 1'b0; ALUOp = '0; funct = '0; op_a = '0; op_b = '0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_hilo", 64'({hi, lo}), 64'(0));
    chk("rst_div0", 64'(div0), 64'(0));
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < NSW; i++) begin
      ALUOp = sw_op[i]; funct = sw_fn[i];
      @(negedge clk);
      chk("dec_code", 64'(ALUCon), 64'(sw_code[i]));
      chk("dec_ill",  64'(illegal), 64'(sw_ill[i]));
      @(posedge clk); #1;
    end

    run_md(6'h18, 32'd7,         32'hFFFF_FFFD, 33, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    run_md(6'h1a, 32'd100,       32'd7,         33, 32'h0000_0002, 32'h0000_000E, 1'b0);
    run_md(6'h1a, 32'hFFFF_FFF9, 32'd2,         33, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_md(6'h1a, 32'd5,         32'd0,          2, 32'h0000_0005, 32'hFFFF_FFFF, 1'b1);
    run_md(6'h18, 32'h0001_2345, 32'h0000_0100, 33, 32'h0000_0000, 32'h0123_4500, 1'b0);
    run_md(6'h18, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 32'h0000_0000, 32'h0000_0006, 1'b0);
    run_md(6'h1a, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0000_0000, 32'h8000_0000, 1'b0);

    // mflo three cycles after a mult
    ALUOp = 6'h00; funct = 6'h18; op_a = 32'd3; op_b = 32'd5; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; funct = 6'h20;
    repeat (2) begin @(posedge clk); #1; end
    funct = 6'h12; in_valid = 1'b1;
    rel = 0;
    for (int n = 3; n <= 80; n++) begin
      @(negedge clk);
      if (!stall) begin
        rel = n;
        break;
      end
      @(posedge clk); #1;
    end
    chk("mflo_release", 64'(rel), 64'(34));
    chk("mflo_lo", 64'(lo), 64'(15));
    @(posedge clk); #1;

    funct = 6'h20; in_valid = 1'b1;
    @(negedge clk);
    chk("add_stall", 64'(stall), 64'(0));
    @(posedge clk); #1;
    ALUOp = 6'h08;
    @(negedge clk);
    chk("addi_stall", 64'(stall), 64'(0));
    @(posedge clk); #1;
    in_valid = 1'b0; ALUOp = 6'h00;

    // reset during a div
    funct = 6'h1a; op_a = 32'd100; op_b = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; funct = 6'h20;
    repeat (9) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_done", 64'(done), 64'(0));
    chk("abort_hilo", 64'({hi, lo}), 64'(0));
    pulses = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("abort_no_done", 64'(pulses), 64'(0));

    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
